// File: rtl/apu_pulse.sv
// apu_pulse: NES APU square-wave (pulse) channel.
//
// Decodes CPU writes to the channel's four registers and runs an 11-bit timer,
// an 8-step duty sequencer, an envelope, a sweep unit and a length counter.
//
// Parameters:
//   CHANNEL       0 = pulse 1 (ones'-complement sweep negate), 1 = pulse 2 (twos'-complement)
// Ports:
//   clk           system clock, one CPU cycle per edge
//   rst_n         asynchronous active-low reset
//   apu_cycle     timer clock enable
//   qtrframe      envelope clock strobe
//   halfframe     length / sweep clock strobe
//   reg_we        register write strobe
//   reg_addr      register select 0..3
//   reg_wdata     register write data
//   enable        channel enable from $4015
//   sample        registered 4-bit channel output
//   length_active registered, 1 when the length counter is non-zero
//
// Build option: define APU_PULSE_SWEEP_EN to include the sweep unit and mute logic.
// Without it reg1 writes are ignored and the channel is never muted by period.
module apu_pulse #(
    parameter int unsigned CHANNEL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       apu_cycle,
    input  logic       qtrframe,
    input  logic       halfframe,
    input  logic       reg_we,
    input  logic [1:0] reg_addr,
    input  logic [7:0] reg_wdata,
    input  logic       enable,
    output logic [3:0] sample,
    output logic       length_active
);

    localparam logic [7:0] LenTable [32] = '{
        8'd10, 8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
        8'd160, 8'd8,  8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
        8'd12, 8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
        8'd192, 8'd24, 8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
    };

    logic [1:0]  duty_q, duty_d;
    logic        halt_q, halt_d;
    logic        cvol_q, cvol_d;
    logic [3:0]  vol_q, vol_d;
    logic [10:0] period_q, period_d;
    logic [10:0] timer_q, timer_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  length_q, length_d;
    logic        env_start_q, env_start_d;
    logic [3:0]  decay_q, decay_d;
    logic [3:0]  env_div_q, env_div_d;
    logic [3:0]  sample_d;
    logic        mute;
    logic [7:0]  duty_pat;
    logic        duty_bit;

`ifdef APU_PULSE_SWEEP_EN
    logic        sweep_en_q, sweep_en_d;
    logic [2:0]  sweep_per_q, sweep_per_d;
    logic        negate_q, negate_d;
    logic [2:0]  shift_q, shift_d;
    logic        sweep_reload_q, sweep_reload_d;
    logic [2:0]  sweep_div_q, sweep_div_d;
    logic [11:0] delta;
    logic [11:0] target;

    assign delta = {1'b0, period_q >> shift_q};

    always_comb begin
        if (!negate_q) begin
            target = {1'b0, period_q} + delta;
        end else if (CHANNEL == 0) begin
            target = {1'b0, period_q} - delta - 12'd1;
        end else begin
            target = {1'b0, period_q} - delta;
        end
    end

    assign mute = (period_q < 11'd8) || (!negate_q && (target > 12'h7FF));
`else
    // CHANNEL only selects the sweep negate flavour, absent in this build.
    logic unused_channel;
    assign unused_channel = (CHANNEL != 0);
    assign mute = 1'b0;
`endif

    always_comb begin
        unique case (duty_q)
            2'd0: duty_pat = 8'b0100_0000;
            2'd1: duty_pat = 8'b0110_0000;
            2'd2: duty_pat = 8'b0111_1000;
            default: duty_pat = 8'b1001_1111;
        endcase
        // Pattern is listed MSB = step 0.
        duty_bit = duty_pat[3'd7 - step_q];
    end

    always_comb begin
        duty_d      = duty_q;
        halt_d      = halt_q;
        cvol_d      = cvol_q;
        vol_d       = vol_q;
        period_d    = period_q;
        timer_d     = timer_q;
        step_d      = step_q;
        length_d    = length_q;
        env_start_d = env_start_q;
        decay_d     = decay_q;
        env_div_d   = env_div_q;
`ifdef APU_PULSE_SWEEP_EN
        sweep_en_d     = sweep_en_q;
        sweep_per_d    = sweep_per_q;
        negate_d       = negate_q;
        shift_d        = shift_q;
        sweep_reload_d = sweep_reload_q;
        sweep_div_d    = sweep_div_q;
`endif

        if (apu_cycle) begin
            if (timer_q == 11'd0) begin
                timer_d = period_q;
                step_d  = step_q - 3'd1;
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end

        if (qtrframe) begin
            if (env_start_q) begin
                env_start_d = 1'b0;
                decay_d     = 4'hF;
                env_div_d   = vol_q;
            end else if (env_div_q == 4'd0) begin
                env_div_d = vol_q;
                if (decay_q != 4'd0) begin
                    decay_d = decay_q - 4'd1;
                end else if (halt_q) begin
                    decay_d = 4'hF;
                end
            end else begin
                env_div_d = env_div_q - 4'd1;
            end
        end

        if (halfframe && (length_q != 8'd0) && !halt_q) begin
            length_d = length_q - 8'd1;
        end

`ifdef APU_PULSE_SWEEP_EN
        if (halfframe) begin
            if ((sweep_div_q == 3'd0) && sweep_en_q && (shift_q != 3'd0) && !mute) begin
                period_d = target[10:0];
            end
            if ((sweep_div_q == 3'd0) || sweep_reload_q) begin
                sweep_div_d    = sweep_per_q;
                sweep_reload_d = 1'b0;
            end else begin
                sweep_div_d = sweep_div_q - 3'd1;
            end
        end
`endif

        // Register writes come last so they win over any strobe update.
        if (reg_we) begin
            unique case (reg_addr)
                2'd0: begin
                    duty_d = reg_wdata[7:6];
                    halt_d = reg_wdata[5];
                    cvol_d = reg_wdata[4];
                    vol_d  = reg_wdata[3:0];
                end
                2'd1: begin
`ifdef APU_PULSE_SWEEP_EN
                    sweep_en_d     = reg_wdata[7];
                    sweep_per_d    = reg_wdata[6:4];
                    negate_d       = reg_wdata[3];
                    shift_d        = reg_wdata[2:0];
                    sweep_reload_d = 1'b1;
`endif
                end
                2'd2: begin
                    period_d[7:0] = reg_wdata;
                end
                default: begin
                    period_d[10:8] = reg_wdata[2:0];
                    if (enable) begin
                        length_d = LenTable[reg_wdata[7:3]];
                    end
                    step_d      = 3'd0;
                    env_start_d = 1'b1;
                end
            endcase
        end

        if (!enable) begin
            length_d = 8'd0;
        end
    end

    assign sample_d = (mute || (length_q == 8'd0) || !duty_bit) ? 4'd0 :
                      (cvol_q ? vol_q : decay_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q        <= 2'd0;
            halt_q        <= 1'b0;
            cvol_q        <= 1'b0;
            vol_q         <= 4'd0;
            period_q      <= 11'd0;
            timer_q       <= 11'd0;
            step_q        <= 3'd0;
            length_q      <= 8'd0;
            env_start_q   <= 1'b0;
            decay_q       <= 4'd0;
            env_div_q     <= 4'd0;
            sample        <= 4'd0;
            length_active <= 1'b0;
`ifdef APU_PULSE_SWEEP_EN
            sweep_en_q     <= 1'b0;
            sweep_per_q    <= 3'd0;
            negate_q       <= 1'b0;
            shift_q        <= 3'd0;
            sweep_reload_q <= 1'b0;
            sweep_div_q    <= 3'd0;
`endif
        end else begin
            duty_q        <= duty_d;
            halt_q        <= halt_d;
            cvol_q        <= cvol_d;
            vol_q         <= vol_d;
            period_q      <= period_d;
            timer_q       <= timer_d;
            step_q        <= step_d;
            length_q      <= length_d;
            env_start_q   <= env_start_d;
            decay_q       <= decay_d;
            env_div_q     <= env_div_d;
            sample        <= sample_d;
            length_active <= (length_q != 8'd0);
`ifdef APU_PULSE_SWEEP_EN
            sweep_en_q     <= sweep_en_d;
            sweep_per_q    <= sweep_per_d;
            negate_q       <= negate_d;
            shift_q        <= shift_d;
            sweep_reload_q <= sweep_reload_d;
            sweep_div_q    <= sweep_div_d;
`endif
        end
    end

endmodule

// File: tb/tb_apu_pulse.sv
// tb_apu_pulse: drives both pulse flavours (CHANNEL 0 and 1) with the same stimulus
// and compares every cycle against a behavioural model of the channel.
module tb_apu_pulse;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       apu_cycle;
    logic       qtrframe;
    logic       halfframe;
    logic       reg_we;
    logic [1:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       enable;
    logic [3:0] sample0, sample1;
    logic       active0, active1;

    bit apu_rand;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    apu_pulse #(.CHANNEL(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .apu_cycle(apu_cycle), .qtrframe(qtrframe),
        .halfframe(halfframe), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .enable(enable), .sample(sample0), .length_active(active0)
    );

    apu_pulse #(.CHANNEL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .apu_cycle(apu_cycle), .qtrframe(qtrframe),
        .halfframe(halfframe), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .enable(enable), .sample(sample1), .length_active(active1)
    );

    // ---------------- reference model ----------------
    int len_tbl [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                         12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};
    int duty_tbl [4] = '{'h40, 'h60, 'h78, 'h9F};

    int m_duty[2], m_halt[2], m_cvol[2], m_vol[2];
    int m_sen[2], m_sper[2], m_neg[2], m_shift[2], m_reload[2], m_sdiv[2];
    int m_period[2], m_timer[2], m_step[2], m_len[2];
    int m_env_start[2], m_decay[2], m_ediv[2];
    int exp_sample[2], exp_active[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_duty[c] = 0; m_halt[c] = 0; m_cvol[c] = 0; m_vol[c] = 0;
            m_sen[c] = 0; m_sper[c] = 0; m_neg[c] = 0; m_shift[c] = 0;
            m_reload[c] = 0; m_sdiv[c] = 0; m_period[c] = 0; m_timer[c] = 0;
            m_step[c] = 0; m_len[c] = 0; m_env_start[c] = 0; m_decay[c] = 0;
            m_ediv[c] = 0; exp_sample[c] = 0; exp_active[c] = 0;
        end
    endtask

    function automatic int sweep_target(int c);
        int delta;
        delta = m_period[c] >> m_shift[c];
        if (m_neg[c] == 0) return m_period[c] + delta;
        return m_period[c] - delta - ((c == 0) ? 1 : 0);
    endfunction

    function automatic bit is_muted(int c);
`ifdef APU_PULSE_SWEEP_EN
        return (m_period[c] < 8) || (m_neg[c] == 0 && sweep_target(c) > 'h7FF);
`else
        return 1'b0;
`endif
    endfunction

    // One clock edge: outputs come from the state before the edge.
    task automatic model_edge(int c);
        bit mute;
        int tgt, dbit;
        mute = is_muted(c);
        tgt  = sweep_target(c);
        dbit = (duty_tbl[m_duty[c]] >> (7 - m_step[c])) & 1;
        exp_sample[c] = (mute || m_len[c] == 0 || dbit == 0) ? 0 :
                        (m_cvol[c] != 0 ? m_vol[c] : m_decay[c]);
        exp_active[c] = (m_len[c] != 0);

        if (apu_cycle) begin
            if (m_timer[c] == 0) begin
                m_timer[c] = m_period[c];
                m_step[c]  = (m_step[c] + 7) % 8;
            end else begin
                m_timer[c]--;
            end
        end
        if (qtrframe) begin
            if (m_env_start[c] != 0) begin
                m_env_start[c] = 0; m_decay[c] = 15; m_ediv[c] = m_vol[c];
            end else if (m_ediv[c] == 0) begin
                m_ediv[c] = m_vol[c];
                if (m_decay[c] > 0) m_decay[c]--;
                else if (m_halt[c] != 0) m_decay[c] = 15;
            end else begin
                m_ediv[c]--;
            end
        end
        if (halfframe && m_len[c] > 0 && m_halt[c] == 0) m_len[c]--;
`ifdef APU_PULSE_SWEEP_EN
        if (halfframe) begin
            if (m_sdiv[c] == 0 && m_sen[c] != 0 && m_shift[c] != 0 && !mute)
                m_period[c] = tgt % 2048;
            if (m_sdiv[c] == 0 || m_reload[c] != 0) begin
                m_sdiv[c] = m_sper[c]; m_reload[c] = 0;
            end else begin
                m_sdiv[c]--;
            end
        end
`endif
        if (reg_we) begin
            case (reg_addr)
                2'd0: begin
                    m_duty[c] = reg_wdata / 64; m_halt[c] = (reg_wdata / 32) % 2;
                    m_cvol[c] = (reg_wdata / 16) % 2; m_vol[c] = reg_wdata % 16;
                end
                2'd1: begin
`ifdef APU_PULSE_SWEEP_EN
                    m_sen[c] = reg_wdata / 128; m_sper[c] = (reg_wdata / 16) % 8;
                    m_neg[c] = (reg_wdata / 8) % 2; m_shift[c] = reg_wdata % 8;
                    m_reload[c] = 1;
`endif
                end
                2'd2: m_period[c] = (m_period[c] / 256) * 256 + reg_wdata;
                default: begin
                    m_period[c] = (reg_wdata % 8) * 256 + m_period[c] % 256;
                    if (enable) m_len[c] = len_tbl[reg_wdata / 8];
                    m_step[c] = 0;
                    m_env_start[c] = 1;
                end
            endcase
        end
        if (!enable) m_len[c] = 0;
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Advance one clock, update the model, compare, then clear the strobes.
    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_eq("sample_ch0", {28'd0, sample0}, exp_sample[0]);
        check_eq("sample_ch1", {28'd0, sample1}, exp_sample[1]);
        check_eq("active_ch0", {31'd0, active0}, exp_active[0]);
        check_eq("active_ch1", {31'd0, active1}, exp_active[1]);
        reg_we    = 1'b0;
        qtrframe  = 1'b0;
        halfframe = 1'b0;
        apu_cycle = apu_rand ? 1'($urandom_range(0, 1)) : ~apu_cycle;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic qtr();
        qtrframe = 1'b1;
        cycle();
    endtask

    task automatic half();
        halfframe = 1'b1;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; apu_cycle = 1'b0; qtrframe = 1'b0; halfframe = 1'b0;
        reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = 8'd0; enable = 1'b1; apu_rand = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_sample0", {28'd0, sample0}, 0);
        check_eq("reset_sample1", {28'd0, sample1}, 0);
        check_eq("reset_active0", {31'd0, active0}, 0);
        check_eq("reset_active1", {31'd0, active1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic tone: duty 2, constant volume 15, period 8, length 10.
        wr(2'd0, 8'hBF); wr(2'd2, 8'h08); wr(2'd3, 8'h00);
        idle(2);
        check_eq("tone_active", {31'd0, active0}, 1);
        idle(200);

        // Envelope decay, then looping decay.
        wr(2'd0, 8'h02); wr(2'd3, 8'h00);
        repeat (50) begin qtr(); idle(3); end
        wr(2'd0, 8'h22);
        repeat (60) begin qtr(); idle(3); end

        // Length counter: index 3 -> 2, two halfframes clear it.
        wr(2'd0, 8'h9F); wr(2'd3, 8'h18);
        half(); idle(2); half(); idle(3);
        check_eq("len_expired", {31'd0, active0}, 0);
        wr(2'd0, 8'hBF); wr(2'd3, 8'h18);
        repeat (3) begin half(); idle(2); end
        check_eq("len_halted", {31'd0, active0}, 1);
        enable = 1'b0; cycle(); cycle();
        check_eq("len_disabled", {31'd0, active1}, 0);
        enable = 1'b1;

        // Sweep: period 0x010 negates to 7 (muted) on ch0, 8 on ch1.
        wr(2'd0, 8'hBF); wr(2'd2, 8'h10); wr(2'd3, 8'h00);
        wr(2'd1, 8'h89); half(); idle(300);
        // Period 0x100 negates to 0x07F / 0x080.
        wr(2'd2, 8'h00); wr(2'd3, 8'h01);
        wr(2'd1, 8'h89); half(); idle(2500);

        // Mute by overflowing target, then by tiny period.
        wr(2'd2, 8'h00); wr(2'd3, 8'h06); wr(2'd1, 8'h81); half(); idle(150);
        wr(2'd1, 8'h00); wr(2'd2, 8'h07); wr(2'd3, 8'h00); idle(100);

        // Collisions: reg3 with halfframe and qtrframe, reg1 with halfframe.
        wr(2'd2, 8'h0C);
        halfframe = 1'b1; qtrframe = 1'b1; wr(2'd3, 8'h08);
        idle(3); qtr(); idle(20);
        halfframe = 1'b1; wr(2'd1, 8'hA9); idle(5); half(); idle(50);

        // Randomized traffic.
        apu_rand = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                reg_we   = 1'b1;
                reg_addr = 2'($urandom_range(0, 3));
                reg_wdata = 8'($urandom);
                if (reg_addr == 2'd3 && $urandom_range(0, 3) != 0) reg_wdata[2:0] = 3'd0;
                if (reg_addr == 2'd2 && $urandom_range(0, 1) == 0)
                    reg_wdata = 8'($urandom_range(0, 31));
            end
            qtrframe  = ($urandom_range(0, 29) == 0);
            halfframe = ($urandom_range(0, 59) == 0);
            if (enable && $urandom_range(0, 499) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            cycle();
        end
        apu_rand = 1'b0;
        enable = 1'b1;

        // Async reset mid-tone.
        wr(2'd0, 8'hBF); wr(2'd1, 8'h00); wr(2'd2, 8'h08); wr(2'd3, 8'h00); idle(40);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_sample0", {28'd0, sample0}, 0);
        check_eq("async_sample1", {28'd0, sample1}, 0);
        check_eq("async_active0", {31'd0, active0}, 0);
        check_eq("async_active1", {31'd0, active1}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apu_pulse.md
# apu_pulse

Square-wave (pulse) channel of the NES APU, the consumer of the frame sequencer's `apu_cycle`, `qtrframe` and `halfframe` strobes. It decodes CPU writes to its four registers ($4000–$4003 or $4004–$4007) and runs an 11-bit timer, an 8-step duty sequencer, an envelope, a sweep unit and a length counter. It produces a 4-bit sample for the APU mixer and a length-active status bit for $4015 reads.

## Interface
- `CHANNEL`, default 0: 0 = pulse 1 (ones'-complement sweep negate); 1 = pulse 2 (twos'-complement negate).
- `clk` input 1: system clock, one CPU cycle per edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `apu_cycle` input 1: timer clock enable; the timer is clocked on cycles where it is high.
- `qtrframe` input 1: envelope clock strobe, one cycle wide.
- `halfframe` input 1: length and sweep clock strobe, one cycle wide.
- `reg_we` input 1: register write strobe, one cycle.
- `reg_addr` input 2: register select, 0–3.
- `reg_wdata` input 8: write data.
- `enable` input 1: channel enable bit from $4015.
- `sample` output 4: registered channel output.
- `length_active` output 1: registered; 1 when the length counter is non-zero.

## Operation
**Register writes**
- reg0 `DDLC VVVV`:
  - DD = duty.
  - L = length halt and envelope loop.
  - C = constant volume.
  - V = volume, also the envelope period.
- reg1 `EPPP NSSS`:
  - E = sweep enable, PPP = sweep period, N = negate, SSS = shift.
  - A write sets `sweep_reload`.
- reg2: `period[7:0]`.
- reg3 `LLLL LTTT`:
  - `period[10:8]` = TTT.
  - Length counter is loaded from the table at index LLLLL, only if `enable` is 1.
  - Sequencer step is reset to 0.
  - `env_start` is set.
- Length table, indices 0–31: 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- `enable` = 0 forces the length counter to 0 every cycle.

**Timer and sequencer** (clocked only when `apu_cycle` = 1)
- If timer = 0: reload timer from `period` and decrement step, wrapping 0→7.
- Otherwise: decrement timer.
- Duty patterns, listed as bits for step 0..7:
  - duty 0: 0100_0000
  - duty 1: 0110_0000
  - duty 2: 0111_1000
  - duty 3: 1001_1111

**Envelope** (on `qtrframe`)
- If `env_start` = 1: clear it, set decay = 15, set divider = V.
- Else if divider = 0: set divider = V; then decay decrements if non-zero, or reloads to 15 if it is 0 and L = 1.
- Else: divider decrements.

**Length counter** (on `halfframe`)
- Decrements if non-zero and L = 0.

**Sweep**
- `delta = period >> S`.
- Target, computed in 12 bits:
  - N = 0: `period + delta`.
  - N = 1, `CHANNEL` = 0: `period - delta - 1`.
  - N = 1, `CHANNEL` = 1: `period - delta`.
- mute = (`period` < 8) OR (N = 0 AND target > 0x7FF). Mute is evaluated continuously, regardless of E.
- On `halfframe`:
  - If sweep divider = 0 AND E AND S ≠ 0 AND !mute: `period` ← `target[10:0]`.
  - Then, if divider = 0 OR `sweep_reload`: divider ← PPP and `sweep_reload` is cleared.
  - Otherwise the divider decrements.

**Output**
- `sample` = 0 if mute, or length = 0, or the duty bit = 0.
- Otherwise `sample` = V when C = 1, else decay.

**Simultaneous events**
- A register write in the same cycle as a strobe: the write wins for every field it writes. A reg3 length load overrides a `halfframe` decrement, and a reg2/reg3 period write overrides a sweep period update.
- A reg1 write coincident with `halfframe`: the sweep step uses the old fields, and `sweep_reload` ends the cycle set.
- A reg3 write coincident with `qtrframe`: `env_start` ends the cycle set, and the envelope step uses the old `env_start`.

## Timing
- Every internal register resets to 0: period, timer, step, length, decay, dividers, flags, and all register fields.
- `sample` and `length_active` reset to 0.
- A write on edge N updates state at edge N. `sample` and `length_active` reflect the new state at edge N+1, a fixed 1-cycle output latency.
- Timer period in CPU clocks: 2·(period+1). One full duty cycle = 16·(period+1) CPU clocks.
- Deasserting `rst_n` mid-operation returns all state to reset values immediately, independent of `clk`.

## Configuration
- `APU_PULSE_SWEEP_EN` defined: sweep unit and mute logic present, as described above.
- `APU_PULSE_SWEEP_EN` undefined:
  - reg1 writes are ignored.
  - `period` changes only through reg2/reg3.
  - mute is constant 0, so periods below 8 are audible.

## Test plan
- reg0 = 0xBF, reg2 = 0x08, reg3 = 0x00, `enable` = 1, `apu_cycle` toggling → `sample` follows duty 2 (0111_1000) at 15, step advance every 18 clocks; `length_active` = 1 with length = 10.
- Envelope: reg0 = 0x02, then reg3 write, then `qtrframe` pulses → decay 15, then it decrements once every 3 `qtrframe` pulses, holds at 0. With reg0 = 0x22 it wraps back to 15.
- Length: reg3 index 3 (length 2), two `halfframe` pulses → `length_active` falls one cycle after the second. With L = 1 it holds. Driving `enable` = 0 clears it immediately.
- Sweep, `CHANNEL` = 0: period = 0x100, reg1 = 0x89 (E, P = 0, N, S = 1), `halfframe` → period 0x07F. Repeat with `CHANNEL` = 1 → period 0x080.
- Mute: period = 0x600, reg1 = 0x81 (N = 0, S = 1) → target 0x900 > 0x7FF, `sample` = 0 with no period update. Period = 7 → `sample` = 0.
- Collisions: reg3 write on the `halfframe` cycle → loaded length is not decremented. Async `rst_n` pulse mid-tone → all outputs 0 without a clock edge.
